adder_arbiter_seq: RTL and testbench

Shares one 8-bit ripple adder between two requesters and sequences it byte-serially to perform (8·NBYTES)-bit additions with carry-in and carry-out. It sits between two client blocks and the 8-bit adder datapath (inputs iData_a, iData_b, iC; outputs oData, oData_C), which it instantiates internally. It provides round-robin arbitration, a grant handshake, multi-cycle carry chaining, and a one-cycle completion pulse tagged with the owning requester.

---
 rtl/adder_arbiter_seq.sv | 155 +++++++++++++++
 tb/tb_adder_arbiter_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter_seq.sv
// Two-requester round-robin front end sharing one 8-bit adder. It performs
// (8*NBYTES)-bit additions byte-serially, chaining the carry from one byte to the next.

module adder8 (
  input  logic [7:0] iData_a,
  input  logic [7:0] iData_b,
  input  logic       iC,
  output logic [7:0] oData,
  output logic       oData_C
);
  assign {oData_C, oData} = {1'b0, iData_a} + {1'b0, iData_b} + {8'b0, iC};
endmodule

module adder_arbiter_seq #(
  parameter int NBYTES = 4
) (
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic                iReq0,
  input  logic                iReq1,
  input  logic [8*NBYTES-1:0] iA0,
  input  logic [8*NBYTES-1:0] iB0,
  input  logic [8*NBYTES-1:0] iA1,
  input  logic [8*NBYTES-1:0] iB1,
  input  logic                iC0,
  input  logic                iC1,
  output logic                oGnt0,
  output logic                oGnt1,
  output logic                oBusy,
  output logic                oDone,
  output logic                oOwner,
  output logic [8*NBYTES-1:0] oData,
  output logic                oData_C
);
  localparam int W  = 8 * NBYTES;
  localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic            carry_q, carry_d;
  logic            ptr_q, ptr_d;
  logic            own_q, own_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [W-1:0]    data_q, data_d;
  logic            dc_q, dc_d;
  logic            owner_q, owner_d;

  logic [7:0]      add_a, add_b, add_s;
  logic            add_co;
  logic [W-1:0]    acc_upd;
  logic            last_byte;

  // Grants depend only on state, requests and the last-served pointer.
  assign oGnt0 = iRst_n && (state_q == S_IDLE) && iReq0 && (!iReq1 || ptr_q);
  assign oGnt1 = iRst_n && (state_q == S_IDLE) && iReq1 && (!iReq0 || !ptr_q);

  assign oBusy   = (state_q != S_IDLE);
  assign oDone   = (state_q == S_DONE);
  assign oOwner  = owner_q;
  assign oData   = data_q;
  assign oData_C = dc_q;

  assign last_byte = (k_q == KW'(NBYTES - 1));

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    acc_upd = acc_q;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (k_q == KW'(i)) begin
        add_a = a_q[8*i +: 8];
        add_b = b_q[8*i +: 8];
        acc_upd[8*i +: 8] = add_s;
      end
    end
  end

  adder8 u_adder (
    .iData_a (add_a),
    .iData_b (add_b),
    .iC      (carry_q),
    .oData   (add_s),
    .oData_C (add_co)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    data_d  = data_q;
    dc_d    = dc_q;
    owner_d = owner_q;
    unique case (state_q)
      S_IDLE: begin
        if (oGnt0) begin
          a_d = iA0; b_d = iB0; carry_d = iC0;
          ptr_d = 1'b0; own_d = 1'b0; k_d = '0; state_d = S_ADD;
        end else if (oGnt1) begin
          a_d = iA1; b_d = iB1; carry_d = iC1;
          ptr_d = 1'b1; own_d = 1'b1; k_d = '0; state_d = S_ADD;
        end
      end
      S_ADD: begin
        acc_d   = acc_upd;
        carry_d = add_co;
        if (last_byte) begin
          k_d     = '0;
          data_d  = acc_upd;
          dc_d    = add_co;
          owner_d = own_q;
          state_d = S_DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      ptr_q   <= 1'b1;
      own_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      dc_q    <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      dc_q    <= dc_d;
      owner_q <= owner_d;
    end
  end
endmodule

// File: tb/tb_adder_arbiter_seq.sv
// Scoreboard bench: expected sums are queued at each accept edge and
// compared against the DUT whenever oDone pulses.

module tb_adder_arbiter_seq;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0, req1, c0, c1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, busy, done, owner, dc;
  logic [W-1:0] data;

  always #5 clk = ~clk;

  adder_arbiter_seq #(.NBYTES(NB)) dut (
    .iClk(clk), .iRst_n(rst_n),
    .iReq0(req0), .iReq1(req1),
    .iA0(a0), .iB0(b0), .iA1(a1), .iB1(b1),
    .iC0(c0), .iC1(c1),
    .oGnt0(gnt0), .oGnt1(gnt1), .oBusy(busy), .oDone(done),
    .oOwner(owner), .oData(data), .oData_C(dc)
  );

  typedef struct packed {
    logic         own;
    logic         c;
    logic [W-1:0] d;
  } res_t;

  int   total = 0;
  int   bad   = 0;
  res_t sb[$];
  logic gnt_log[$];
  int   cyc = 0;
  int   done_cnt = 0;
  int   acc_cyc = 0;
  int   done_cyc = 0;
  int   busy_cnt = 0;
  bit   gap_chk = 0;
  bit   gap_armed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    model = {o, s[W], s[W-1:0]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change only just after posedge, so negedge values are what the next edge samples.
  always @(negedge clk) begin
    res_t r;
    if (rst_n && req0 && gnt0) begin
      sb.push_back(model(1'b0, a0, b0, c0)); gnt_log.push_back(1'b0); acc_cyc = cyc + 1;
    end
    if (rst_n && req1 && gnt1) begin
      sb.push_back(model(1'b1, a1, b1, c1)); gnt_log.push_back(1'b1); acc_cyc = cyc + 1;
    end
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      if (gap_chk && gap_armed) check("done_gap", cyc - done_cyc, NB + 2);
      gap_armed = 1;
      done_cyc  = cyc;
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        r = sb.pop_front();
        check("data", data, r.d);
        check("carry", dc, r.c);
        check("owner", owner, r.own);
      end
    end
  end

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (done_cnt < target) check("timeout_done", done_cnt, target);
  endtask

  task automatic wait_gnt(input bit idx);
    int n = 0;
    do begin
      @(negedge clk); n++;
    end while (!(idx ? gnt1 : gnt0) && n < 50);
    if (!(idx ? gnt1 : gnt0)) check("timeout_gnt", 0, 1);
  endtask

  task automatic run_single(input bit idx, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c);
    int t;
    t = done_cnt + 1;
    if (idx) begin a1 = a; b1 = b; c1 = c; req1 = 1; end
    else     begin a0 = a; b0 = b; c0 = c; req0 = 1; end
    wait_gnt(idx);
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    wait_done(t);
  endtask

  initial begin
    int t, viol, d0;
    rst_n = 0; req0 = 1; req1 = 0;
    a0 = 32'h0000000D; b0 = 32'h00000002; c0 = 0;
    a1 = '0; b1 = '0; c1 = 0;

    // Reset hold with a pending request.
    repeat (3) begin
      @(negedge clk);
      check("rst_hold", {gnt0, gnt1, busy, done, owner, dc, data}, 0);
    end
    @(posedge clk); #1 rst_n = 1; #1;
    check("gnt0_after_rst", gnt0, 1);
    busy_cnt = 0;
    @(posedge clk); #1 req0 = 0;
    wait_done(1);
    check("latency", done_cyc - acc_cyc, NB);
    check("busy_cycles", busy_cnt, NB + 1);

    run_single(0, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    run_single(0, 32'h00FFFFFF, 32'h00000001, 1'b0);

    // Request raised while busy must wait for the IDLE cycle after DONE.
    t = done_cnt + 2;
    a0 = 32'h12345678; b0 = 32'h0F0F0F0F; c0 = 0; req0 = 1;
    wait_gnt(0);
    @(posedge clk); #1 req0 = 0;
    @(posedge clk); #1;
    a1 = 32'h80000000; b1 = 32'h80000001; c1 = 1; req1 = 1;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      if (gnt1) viol++;
    end
    check("gnt1_while_busy", viol, 0);
    check("gnt1_in_idle", gnt1, 1);
    @(posedge clk); #1 req1 = 0;
    wait_done(t);

    // Contention: both held, expect 0,1,0,1 at NB+2 spacing.
    gnt_log.delete();
    a0 = 32'h55555555; b0 = 32'hAAAAAAA6; c0 = 1;
    a1 = 32'hADADADAD; b1 = 32'hB2B2B2B2; c1 = 0;
    t = done_cnt + 4;
    gap_chk = 1; gap_armed = 0;
    @(posedge clk); #1 req0 = 1; req1 = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (done_cnt >= t) break;
    end
    req0 = 0; req1 = 0;
    gap_chk = 0;
    check("contention_dones", done_cnt, t);
    check("contention_grants", gnt_log.size(), 4);
    for (int i = 0; i < gnt_log.size() && i < 4; i++)
      check($sformatf("grant_order%0d", i), gnt_log[i], i % 2);

    // Reset during the second ADD cycle abandons the operation.
    a0 = 32'h01020304; b0 = 32'h10203040; c0 = 0;
    @(posedge clk); #1 req0 = 1;
    wait_gnt(0);
    @(posedge clk); #1 req0 = 0;
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    sb.delete();
    d0 = done_cnt;
    check("mid_rst_out", {busy, done, owner, dc, data}, 0);
    repeat (8) @(negedge clk);
    check("mid_rst_no_done", done_cnt, d0);

    // Tie after reset goes to requester 0.
    a0 = 32'h0000FFFF; b0 = 32'h0000FFFF; c0 = 1;
    a1 = 32'hDEADBEEF; b1 = 32'h21524111; c1 = 0;
    @(posedge clk); #1 req0 = 1; req1 = 1; #1;
    check("tie_gnt", {gnt0, gnt1}, 2'b10);
    @(posedge clk); #1 req0 = 0;
    wait_gnt(1);
    @(posedge clk); #1 req1 = 0;
    wait_done(d0 + 2);
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
